memwb_stage_rv: RTL

//  Next-generation MEM->WB pipeline stage: parametrised ARQ-bit datapath with valid/ready handshake,
//  2-entry skid buffer (full throughput under back-pressure), synchronous flush, writeback-source

---
 rtl/memwb_pkg.sv | 33 +++
 rtl/memwb_stage_rv_if.sv | 43 ++++
 rtl/memwb_stage_rv_skid_reg2.sv | 98 +++++++++
 rtl/memwb_stage_rv.sv | 81 ++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared types for the MEM->WB stage: writeback source select, skid occupancy states
// and the captured entry payload.
package memwb_pkg;

   localparam int unsigned MEMWB_ARQ    = 16;
   localparam int unsigned MEMWB_DEST_W = 3;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_IMM  = 2'd2,
      WB_ALU2 = 2'd3
   } wb_sel_e;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   typedef struct packed {
      wb_sel_e                 wb_sel;
      logic                    wb_en;
      logic                    pc_en;
      logic [MEMWB_ARQ-1:0]    alu;
      logic [MEMWB_ARQ-1:0]    mem;
      logic [MEMWB_ARQ-1:0]    imm;
      logic [MEMWB_DEST_W-1:0] dest;
   } memwb_payload_t;

   localparam int unsigned MEMWB_PAYLOAD_W = $bits(memwb_payload_t);

endpackage

// File: rtl/memwb_stage_rv_if.sv
// MEM->WB stage bus: upstream handshake/payload, downstream head outputs, forwarding tap,
// flush and stall counter. master = surrounding pipeline, slave = the stage.
interface memwb_stage_rv_if #(
   parameter int unsigned ARQ    = 16,
   parameter int unsigned DEST_W = 3,
   parameter int unsigned CNT_W  = 16
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_wb_sel;
   logic              in_wb_en;
   logic              in_pc_en;
   logic [ARQ-1:0]    in_alu;
   logic [ARQ-1:0]    in_mem;
   logic [ARQ-1:0]    in_imm;
   logic [DEST_W-1:0] in_dest;
   logic              out_valid;
   logic              out_ready;
   logic              out_wb_en;
   logic              out_pc_en;
   logic [ARQ-1:0]    out_wb_data;
   logic [DEST_W-1:0] out_wb_dest;
   logic              fwd_valid;
   logic [DEST_W-1:0] fwd_dest;
   logic [ARQ-1:0]    fwd_data;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output flush, in_valid, in_wb_sel, in_wb_en, in_pc_en, in_alu, in_mem, in_imm, in_dest,
      output out_ready,
      input  in_ready, out_valid, out_wb_en, out_pc_en, out_wb_data, out_wb_dest,
      input  fwd_valid, fwd_dest, fwd_data, stall_cnt
   );

   modport slave (
      input  flush, in_valid, in_wb_sel, in_wb_en, in_pc_en, in_alu, in_mem, in_imm, in_dest,
      input  out_ready,
      output in_ready, out_valid, out_wb_en, out_pc_en, out_wb_data, out_wb_dest,
      output fwd_valid, fwd_dest, fwd_data, stall_cnt
   );

endinterface

// File: rtl/memwb_stage_rv_skid_reg2.sv
// Generic 2-entry valid/ready skid register with synchronous flush. Upstream ready is a
// pure function of registered occupancy, so there is no combinational ready path.
module skid_reg2
   import memwb_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   skid_state_e      r_state;
   skid_state_e      w_state_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             w_accept;
   logic             w_retire;
   logic             w_load_main_in;
   logic             w_load_main_skid;
   logic             w_load_skid;

   assign o_ready  = (r_state != SKID_FULL);
   assign o_valid  = (r_state != SKID_EMPTY);
   assign o_data   = r_main;
   assign w_accept = i_valid & o_ready;
   assign w_retire = o_valid & i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SKID_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         SKID_EMPTY: begin
            if (w_accept) begin
               w_state_nxt    = SKID_ONE;
               w_load_main_in = 1'b1;
            end
         end
         SKID_ONE: begin
            if (w_accept && w_retire) begin
               w_load_main_in = 1'b1;
            end else if (w_accept) begin
               w_state_nxt = SKID_FULL;
               w_load_skid = 1'b1;
            end else if (w_retire) begin
               w_state_nxt = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (w_retire) begin
               w_state_nxt      = SKID_ONE;
               w_load_main_skid = 1'b1;
            end
         end
         default: w_state_nxt = SKID_EMPTY;
      endcase
      // Flush drops any same-cycle accept; a same-cycle retire has already been delivered.
      if (i_flush) begin
         w_state_nxt      = SKID_EMPTY;
         w_load_main_in   = 1'b0;
         w_load_main_skid = 1'b0;
         w_load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main <= i_data;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= i_data;
         end
      end
   end

endmodule

// File: rtl/memwb_stage_rv.sv
// MEM->WB pipeline stage: skid-buffered entries, writeback source mux on the head entry,
// valid-qualified outputs, WB->EX forwarding tap and saturating stall counter.
module memwb_stage_rv
   import memwb_pkg::*;
#(
   parameter int unsigned ARQ    = MEMWB_ARQ,
   parameter int unsigned DEST_W = MEMWB_DEST_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   memwb_stage_rv_if.slave   bus
);

   memwb_payload_t    w_in_pl;
   memwb_payload_t    w_head_pl;
   logic              w_head_valid;
   logic              w_in_ready;
   logic [ARQ-1:0]    w_wb_data;
   logic [DEST_W-1:0] w_wb_dest;
   logic              w_head_wb_en;
   logic [CNT_W-1:0]  r_stall_cnt;

   always_comb begin
      w_in_pl        = '0;
      w_in_pl.wb_sel = wb_sel_e'(bus.in_wb_sel);
      w_in_pl.wb_en  = bus.in_wb_en;
      w_in_pl.pc_en  = bus.in_pc_en;
      w_in_pl.alu    = bus.in_alu;
      w_in_pl.mem    = bus.in_mem;
      w_in_pl.imm    = bus.in_imm;
      w_in_pl.dest   = bus.in_dest;
   end

   skid_reg2 #(
      .WIDTH (MEMWB_PAYLOAD_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.flush),
      .i_valid (bus.in_valid),
      .o_ready (w_in_ready),
      .i_data  (w_in_pl),
      .o_valid (w_head_valid),
      .i_ready (bus.out_ready),
      .o_data  (w_head_pl)
   );

   // Entries are stored raw; the source select is resolved only on the head entry.
   always_comb begin
      w_wb_data = w_head_pl.alu;
      case (w_head_pl.wb_sel)
         WB_MEM:  w_wb_data = w_head_pl.mem;
         WB_IMM:  w_wb_data = w_head_pl.imm;
         default: w_wb_data = w_head_pl.alu;
      endcase
   end

   assign w_wb_dest    = w_head_pl.dest;
   assign w_head_wb_en = w_head_valid & w_head_pl.wb_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_head_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = w_head_valid;
   assign bus.out_wb_en   = w_head_wb_en;
   assign bus.out_pc_en   = w_head_valid & w_head_pl.pc_en;
   assign bus.out_wb_data = w_wb_data;
   assign bus.out_wb_dest = w_wb_dest;
   assign bus.fwd_valid   = w_head_wb_en;
   assign bus.fwd_dest    = w_wb_dest;
   assign bus.fwd_data    = w_wb_data;
   assign bus.stall_cnt   = r_stall_cnt;

endmodule
